// File: rtl/jk_bank_arbiter.sv
// Shared JK flip-flop bank with four requesters arbitrated round-robin.
// Each command takes IDLE -> GRANT -> COMMIT. q updates on the edge that leaves COMMIT.

module jk_bank_cell (
   input  logic clk,
   input  logic reset_n,
   input  logic i_en,
   input  logic i_j,
   input  logic i_k,
   output logic o_q
);
   logic r_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= 1'b0;
      end else if (i_en) begin
         case ({i_j, i_k})
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            2'b11:   r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;
endmodule

module jk_bank_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_mask,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        q,
   output logic [1:0]              grant_id,
   output logic                    busy,
   output logic                    done
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COMMIT} state_t;

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] mask;
   } cmd_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_rr_ptr;
   logic [1:0]       r_grant;
   cmd_t             r_cmd;
   logic [1:0]       w_win;
   logic             w_any;
   logic             w_cap;
   logic             w_commit;
   logic [NREQ-1:0]  w_ready;
   logic [WIDTH-1:0] w_q;

   // First valid requester scanning upward from r_rr_ptr, wrapping 3 -> 0.
   always_comb begin : p_rr
      logic       found;
      logic [1:0] idx;
      w_win = r_rr_ptr;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < NREQ; i++) begin
         idx = r_rr_ptr + 2'(i);
         if (!found && req_valid[idx]) begin
            w_win = idx;
            found = 1'b1;
         end
      end
      w_any = found;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_cap       = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) w_state_nxt = S_GRANT;
         end
         S_GRANT: begin
            if (req_valid[r_grant]) begin
               w_ready[r_grant] = 1'b1;
               w_cap            = 1'b1;
               w_state_nxt      = S_COMMIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= 2'd0;
         r_grant  <= 2'd0;
         r_cmd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_any) r_grant <= w_win;
         if (w_cap) begin
            r_cmd.op   <= req_op[2*r_grant +: 2];
            r_cmd.mask <= req_mask[WIDTH*r_grant +: WIDTH];
         end
         if (w_commit) r_rr_ptr <= r_grant + 2'd1;
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      jk_bank_cell u_cell (
         .clk     (clk),
         .reset_n (reset_n),
         .i_en    (w_commit & r_cmd.mask[b]),
         .i_j     (r_cmd.op[1]),
         .i_k     (r_cmd.op[0]),
         .o_q     (w_q[b])
      );
   end

   assign q         = w_q;
   assign req_ready = w_ready;
   assign grant_id  = r_grant;
   assign busy      = (r_state != S_IDLE);
   assign done      = w_commit;
endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the number of JK flip-flop bits in the shared bank.
REQ-002: Parameter NREQ, default 4, SHALL set the number of requesters; NREQ is fixed at 4 in this revision.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: req_valid  input  NREQ  SHALL carry per-requester command-valid.
REQ-006: req_op  input  2*NREQ  SHALL carry per-requester op; requester i uses bits [2i+1:2i].
REQ-007: req_mask  input  WIDTH*NREQ  SHALL carry per-requester bit-select mask; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008: req_ready  output  NREQ  SHALL be the per-requester accept strobe, at most one bit high per cycle.
REQ-009: q  output  WIDTH  SHALL be the current JK bank state.
REQ-010: grant_id  output  2  SHALL be the index of the requester currently granted.
REQ-011: busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012: done  output  1  SHALL pulse high for one cycle when a command commits to q.

Function
REQ-013: Op encoding SHALL follow JK semantics per masked bit: 00 HOLD (J=0,K=0), 01 CLEAR (J=0,K=1), 10 SET (J=1,K=0), 11 TOGGLE (J=1,K=1).
REQ-014: Bits with mask=0 SHALL hold their value regardless of op.
REQ-015: FSM SHALL have states IDLE, GRANT, COMMIT.
REQ-016: IDLE: if any req_valid is high, the winner SHALL be chosen round-robin starting at pointer rr_ptr, latched into grant_id, and the FSM SHALL move to GRANT; otherwise it stays in IDLE.
REQ-017: GRANT: if req_valid[grant_id] is high, req_ready[grant_id] SHALL be high this cycle, op and mask SHALL be captured, and the FSM SHALL move to COMMIT.
REQ-018: GRANT: if req_valid[grant_id] is low (requester withdrew), the FSM SHALL return to IDLE with no ready, no done, no q change, and rr_ptr unchanged.
REQ-019: COMMIT: q SHALL be updated per REQ-013/014 with the captured op and mask, done SHALL be high, rr_ptr SHALL become (grant_id+1) mod 4 with wrap from 3 to 0, and the FSM SHALL return to IDLE.
REQ-020: Latency from req_valid rising (sampled in IDLE) to q update SHALL be 3 rising edges; minimum spacing between commits SHALL be 3 cycles.
REQ-021: Requesters SHALL hold req_valid, req_op and req_mask stable until req_ready; the block ignores op/mask changes after capture.
REQ-022: With all four requesters continuously valid, grants SHALL rotate rr_ptr-first in order 0,1,2,3,0...; no requester waits more than 3 other commits.
REQ-023: req_ready SHALL be low in IDLE and COMMIT; done SHALL be low in IDLE and GRANT.
REQ-024: Simultaneous new req_valid during GRANT/COMMIT SHALL be held pending and considered only at the next IDLE evaluation.

Reset
REQ-025: While reset_n is low, q SHALL be all zeros, FSM in IDLE, rr_ptr=0, grant_id=0, req_ready=0, busy=0, done=0, independent of clk.
REQ-026: Reset asserted mid-operation (GRANT or COMMIT) SHALL abort the command with no q update, and operation SHALL resume from IDLE with rr_ptr=0 on the first rising edge after reset_n deasserts.

Verification
REQ-027: Reset then req_valid=0001, op0=10, mask0=0xF0 -> req_ready=0001 in GRANT, q=0xF0 and done=1 three edges after valid sampled, rr_ptr=1.
REQ-028: From q=0xF0, requester 2 op=11 mask=0xFF -> q=0x0F; then op=01 mask=0x0C -> q=0x03; then op=00 mask=0xFF -> q=0x03 with done=1.
REQ-029: All req_valid=1111 held for 12 commits, each requester SETting a distinct bit -> grant_id sequence 0,1,2,3 repeated, each req_ready once per 12 cycles.
REQ-030: Requester 1 granted then drops req_valid before GRANT -> no ready, no done, q unchanged, next winner still from rr_ptr=1.
REQ-031: reset_n pulsed low during COMMIT with op=10 mask=0xFF pending -> q=0x00 immediately, busy=0, no done; post-release grant starts at requester 0.
REQ-032: Requester 3 commits then requesters 0 and 3 both valid -> requester 0 granted first (wrap from 3 to 0).
